// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared segment codes and display state type for the stopwatch display driver
package rtc_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low patterns, bit0=a .. bit6=g, bit7=dp held off
  localparam logic [7:0] SEG_LUT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  typedef enum logic {
    LIVE   = 1'b0,
    FROZEN = 1'b1
  } disp_state_t;

endpackage

// File: rtl/rtc_bcd_to_seg.sv
// rtl/rtc_bcd_to_seg.sv - combinational BCD nibble to active-low 7-segment pattern
module rtc_bcd_to_seg
  import rtc_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  // Blank wins; non-decimal nibbles show a dash so bad data is visible
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (nibble <= 4'd9) begin
      seg = SEG_LUT[nibble];
    end
  end

endmodule

// File: rtl/rtc_displaydriver.sv
// rtl/rtc_displaydriver.sv - six-digit 7-segment driver with lap freeze, leading-zero blank and paused blink
module rtc_displaydriver
  import rtc_pkg::*;
#(
  parameter int BLINK_DIV = 50_000_000,
  parameter int LZ_BLANK  = 1
) (
  input  logic        i_sclk,
  input  logic        i_reset_n,
  input  logic [23:0] i_digit_bcd,
  input  logic        i_valid,
  input  logic        i_running,
  input  logic        i_lap,
  output logic [7:0]  o_segout1,
  output logic [7:0]  o_segout2,
  output logic [7:0]  o_segout3,
  output logic [7:0]  o_segout4,
  output logic [7:0]  o_segout5,
  output logic [7:0]  o_segout6,
  output logic        o_lap_active
);

  localparam int          CNT_W      = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [7:0]  SEG_RST_HI = (LZ_BLANK != 0) ? SEG_BLANK : SEG_LUT[0];

  disp_state_t       state, state_nxt;
  logic [23:0]       disp, disp_nxt;
  logic [23:0]       shadow;
  logic [CNT_W-1:0]  blink_cnt;
  logic              phase_on;
  logic              blink_act;
  logic [5:0]        blank;
  logic [5:0][7:0]   seg_enc;
  logic [5:0][7:0]   seg_q;

  // State, shown value and latest-input shadow; shadow captures every strobe regardless of state
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= LIVE;
      disp   <= '0;
      shadow <= '0;
    end else begin
      state <= state_nxt;
      disp  <= disp_nxt;
      if (i_valid) begin
        shadow <= i_digit_bcd;
      end
    end
  end

  // LIVE follows the input; FROZEN holds until the next lap strobe, then jumps to the newest value
  always_comb begin
    state_nxt = state;
    disp_nxt  = disp;
    case (state)
      LIVE: begin
        if (i_valid) disp_nxt = i_digit_bcd;
        if (i_lap)   state_nxt = FROZEN;
      end
      FROZEN: begin
        if (i_lap) begin
          state_nxt = LIVE;
          disp_nxt  = i_valid ? i_digit_bcd : shadow;
        end
      end
      default: state_nxt = LIVE;
    endcase
  end

  assign o_lap_active = (state == FROZEN);

  // Leading-zero chain: a digit blanks only if it is zero and everything above it is blank
  always_comb begin
    blank    = '0;
    blank[5] = (LZ_BLANK != 0) && (disp[23:20] == 4'd0);
    blank[4] = blank[5] && (disp[19:16] == 4'd0);
    blank[3] = blank[4] && (disp[15:12] == 4'd0);
  end

  for (genvar g = 0; g < 6; g++) begin : g_enc
    rtc_bcd_to_seg u_enc (
      .nibble (disp[4*g +: 4]),
      .blank  (blank[g]),
      .seg    (seg_enc[g])
    );
  end

  assign blink_act = (state == LIVE) && !i_running && (disp != 24'd0);

  // Blink half-period counter; parked at zero with phase ON whenever blinking is not wanted
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (!blink_act) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Registered outputs: encoded shown value, or all dark during the blink OFF phase
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seg_q[5] <= SEG_RST_HI;
      seg_q[4] <= SEG_RST_HI;
      seg_q[3] <= SEG_RST_HI;
      seg_q[2] <= SEG_LUT[0];
      seg_q[1] <= SEG_LUT[0];
      seg_q[0] <= SEG_LUT[0];
    end else begin
      for (int i = 0; i < 6; i++) begin
        seg_q[i] <= (blink_act && !phase_on) ? SEG_BLANK : seg_enc[i];
      end
    end
  end

  assign o_segout1 = seg_q[0];
  assign o_segout2 = seg_q[1];
  assign o_segout3 = seg_q[2];
  assign o_segout4 = seg_q[3];
  assign o_segout5 = seg_q[4];
  assign o_segout6 = seg_q[5];

endmodule
